grn_attractor_ctrl: RTL and testbench

//  Sequencer for a bank of NUM_NODES dual-copy Boolean network nodes. Each node holds
//  a tortoise copy s0, which advances on every 2nd start_s0 pulse after a load, and a

---
 rtl/grn_attractor_ctrl_if.sv | 16 +
 rtl/grn_attractor_ctrl.sv | 138 +++++++++++++
 tb/tb_grn_attractor_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/grn_attractor_ctrl_if.sv
// Result stream carrying one attractor search outcome per initial state.
// The controller drives the master side; the consumer drives ready.
interface grn_attractor_ctrl_if #(
    parameter int unsigned NUM_NODES = 8,
    parameter int unsigned STEP_W    = 7
) ();
    logic                 valid;
    logic                 ready;
    logic [NUM_NODES-1:0] init;
    logic [NUM_NODES-1:0] attr;
    logic [STEP_W-1:0]    steps;
    logic                 timeout;

    modport master (output valid, init, attr, steps, timeout, input ready);
    modport slave  (input valid, init, attr, steps, timeout, output ready);
endinterface

// File: rtl/grn_attractor_ctrl.sv
// Sweeps a range of initial states through a dual-copy (tortoise/hare) Boolean
// network node bank and reports the attractor reached from each one.
module grn_attractor_ctrl #(
    parameter int unsigned NUM_NODES = 8,
    parameter int unsigned CNT_W     = 9,
    parameter int unsigned MAX_STEPS = 64,
    parameter int unsigned STEP_W    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [NUM_NODES-1:0]  i_init_base,
    input  logic [CNT_W-1:0]      i_init_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_reset_nos,
    output logic [NUM_NODES-1:0]  o_init_state,
    output logic                  o_start_s0,
    output logic                  o_start_s1,
    input  logic [NUM_NODES-1:0]  i_s0_vec,
    input  logic [NUM_NODES-1:0]  i_s1_vec,
    grn_attractor_ctrl_if.master  o_res
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStep,
        StCmp,
        StEmit,
        StFin
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [NUM_NODES-1:0] r_cur;
    logic [CNT_W-1:0]     r_rem;
    logic [STEP_W-1:0]    r_steps;
    logic [NUM_NODES-1:0] r_out_init;
    logic [NUM_NODES-1:0] r_out_attr;
    logic [STEP_W-1:0]    r_out_steps;
    logic                 r_out_timeout;
    logic                 w_meet;
    logic                 w_budget;

    // Odd step counts are skipped: the tortoise only moves on even hare steps.
    assign w_meet   = ~r_steps[0] && (i_s0_vec == i_s1_vec);
    assign w_budget = (r_steps == STEP_W'(MAX_STEPS));

    assign o_res.init    = r_out_init;
    assign o_res.attr    = r_out_attr;
    assign o_res.steps   = r_out_steps;
    assign o_res.timeout = r_out_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_cur         <= '0;
            r_rem         <= '0;
            r_steps       <= '0;
            r_out_init    <= '0;
            r_out_attr    <= '0;
            r_out_steps   <= '0;
            r_out_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_cur <= i_init_base;
                        r_rem <= i_init_count;
                    end
                end
                StLoad: r_steps <= '0;
                StStep: r_steps <= r_steps + STEP_W'(1);
                StCmp: begin
                    if (w_meet || w_budget) begin
                        r_out_init    <= r_cur;
                        r_out_attr    <= i_s1_vec;
                        r_out_steps   <= r_steps;
                        r_out_timeout <= ~w_meet;
                    end
                end
                StEmit: begin
                    if (o_res.ready) begin
                        r_rem <= r_rem - CNT_W'(1);
                        r_cur <= r_cur + NUM_NODES'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        o_reset_nos  = 1'b0;
        o_init_state = '0;
        o_start_s0   = 1'b0;
        o_start_s1   = 1'b0;
        o_res.valid  = 1'b0;
        case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_next = (i_init_count == '0) ? StFin : StLoad;
                end
            end
            StLoad: begin
                o_reset_nos  = 1'b1;
                o_init_state = r_cur;
                w_state_next = StStep;
            end
            StStep: begin
                o_start_s0   = 1'b1;
                o_start_s1   = 1'b1;
                w_state_next = StCmp;
            end
            StCmp: begin
                w_state_next = (w_meet || w_budget) ? StEmit : StStep;
            end
            StEmit: begin
                o_res.valid = 1'b1;
                if (o_res.ready) begin
                    w_state_next = (r_rem == CNT_W'(1)) ? StFin : StLoad;
                end
            end
            StFin: begin
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Directed bench for grn_attractor_ctrl with a behavioural tortoise/hare node bank
// supporting identity, low-nibble rotate and increment next-state functions.
module tb_grn_attractor_ctrl;

    localparam int unsigned NN = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NN-1:0] init_base;
    logic [8:0]    init_count;
    logic          busy, done, reset_nos, start_s0, start_s1;
    logic [NN-1:0] init_state, s0, s1;

    grn_attractor_ctrl_if #(.NUM_NODES(NN), .STEP_W(7)) res_if ();

    grn_attractor_ctrl #(
        .NUM_NODES(NN), .CNT_W(9), .MAX_STEPS(64), .STEP_W(7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_init_base (init_base),
        .i_init_count(init_count),
        .o_busy      (busy),
        .o_done      (done),
        .o_reset_nos (reset_nos),
        .o_init_state(init_state),
        .o_start_s0  (start_s0),
        .o_start_s1  (start_s1),
        .i_s0_vec    (s0),
        .i_s1_vec    (s1),
        .o_res       (res_if)
    );

    always #5 clk = ~clk;

    // Node bank model: mode 0 identity, 1 rotate low nibble, 2 increment.
    int   net_mode = 0;
    logic phase;

    function automatic logic [NN-1:0] f(input logic [NN-1:0] x, input int m);
        if (m == 0) return x;
        if (m == 1) return {x[7:4], x[2:0], x[3]};
        return x + 8'd1;
    endfunction

    always @(posedge clk) begin
        if (reset_nos) begin
            s0    <= init_state;
            s1    <= init_state;
            phase <= 1'b0;
        end else begin
            if (start_s1) s1 <= f(s1, net_mode);
            if (start_s0) begin
                phase <= ~phase;
                if (phase) s0 <= f(s0, net_mode);
            end
        end
    end

    int cyc = 0;
    int n_s1 = 0;
    int n_strobe = 0;
    int load_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (start_s1) n_s1 = n_s1 + 1;
        if (start_s0 || start_s1 || reset_nos) n_strobe = n_strobe + 1;
        if (reset_nos) load_cyc = cyc;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [NN-1:0] base, input logic [8:0] cnt);
        start      = 1'b1;
        init_base  = base;
        init_count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (res_if.valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int            mode;
        logic [NN-1:0] base;
        logic [NN-1:0] attr;
        int            steps;
        bit            timeout;
    } vec_t;

    vec_t vecs[6];
    bit   ok;
    int   s1_before, strobe_before, lat;

    initial begin
        vecs[0] = '{mode: 0, base: 8'h5A, attr: 8'h5A, steps: 2,  timeout: 1'b0};
        vecs[1] = '{mode: 1, base: 8'h01, attr: 8'h01, steps: 8,  timeout: 1'b0};
        vecs[2] = '{mode: 1, base: 8'h35, attr: 8'h35, steps: 4,  timeout: 1'b0};
        vecs[3] = '{mode: 1, base: 8'hAF, attr: 8'hAF, steps: 2,  timeout: 1'b0};
        vecs[4] = '{mode: 2, base: 8'h10, attr: 8'h50, steps: 64, timeout: 1'b1};
        vecs[5] = '{mode: 2, base: 8'hF0, attr: 8'h30, steps: 64, timeout: 1'b1};

        rst          = 1'b1;
        start        = 1'b0;
        init_base    = '0;
        init_count   = '0;
        res_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, reset_nos, start_s0, start_s1, res_if.valid,
                           res_if.timeout}, 0);
        chk("reset_data", {init_state, res_if.init, res_if.attr, res_if.steps}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            net_mode  = vecs[v].mode;
            s1_before = n_s1;
            start_run(vecs[v].base, 9'd1);
            wait_valid(ok);
            chk($sformatf("v%0d_valid_seen", v), 64'(ok), 1);
            lat = cyc - load_cyc;
            chk($sformatf("v%0d_init", v), 64'(res_if.init), 64'(vecs[v].base));
            chk($sformatf("v%0d_attr", v), 64'(res_if.attr), 64'(vecs[v].attr));
            chk($sformatf("v%0d_steps", v), 64'(res_if.steps), 64'(vecs[v].steps));
            chk($sformatf("v%0d_timeout", v), 64'(res_if.timeout), 64'(vecs[v].timeout));
            chk($sformatf("v%0d_latency", v), 64'(lat), 64'(1 + 2 * vecs[v].steps));
            chk($sformatf("v%0d_s1_pulses", v), 64'(n_s1 - s1_before), 64'(vecs[v].steps));
            @(negedge clk);
            wait_done(ok);
            chk($sformatf("v%0d_done", v), 64'(ok), 1);
            @(negedge clk);
            chk($sformatf("v%0d_idle", v), 64'(busy), 0);
        end

        // Backpressure: result must hold with no node activity until ready.
        net_mode     = 1;
        res_if.ready = 1'b0;
        start_run(8'h01, 9'd1);
        wait_valid(ok);
        chk("bp_valid_seen", 64'(ok), 1);
        strobe_before = n_strobe;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", i), {res_if.valid, res_if.init, res_if.attr,
                                             1'b0, res_if.steps, res_if.timeout},
                {1'b1, 8'h01, 8'h01, 8'd8, 1'b0});
        end
        chk("bp_no_strobes", 64'(n_strobe - strobe_before), 0);
        res_if.ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", {res_if.valid, done}, 2'b01);
        @(negedge clk);

        // Two-state sweep wrapping the initial state counter.
        net_mode = 0;
        start_run(8'hFF, 9'd2);
        wait_valid(ok);
        chk("wrap_first", {ok, res_if.init, res_if.attr}, {1'b1, 8'hFF, 8'hFF});
        @(negedge clk);
        chk("wrap_reload", {res_if.valid, reset_nos, init_state}, {1'b0, 1'b1, 8'h00});
        wait_valid(ok);
        chk("wrap_second", {ok, res_if.init, res_if.attr}, {1'b1, 8'h00, 8'h00});
        @(negedge clk);
        chk("wrap_done", 64'(done), 1);
        @(negedge clk);

        // Empty sweep goes straight to FIN.
        strobe_before = n_strobe;
        start_run(8'h33, 9'd0);
        chk("cnt0_fin", {done, busy, res_if.valid}, 3'b110);
        @(negedge clk);
        chk("cnt0_idle", {done, busy}, 2'b00);
        chk("cnt0_no_strobes", 64'(n_strobe - strobe_before), 0);

        // Mid-run reset, then start pulses while busy are ignored.
        net_mode = 2;
        start_run(8'h44, 9'd3);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outputs", {busy, done, reset_nos, start_s0, start_s1, res_if.valid,
                            res_if.timeout, init_state, res_if.attr, res_if.steps}, 0);
        repeat (2) @(negedge clk);
        chk("rst_stays_idle", {busy, res_if.valid}, 0);

        start_run(8'h20, 9'd1);
        repeat (3) @(negedge clk);
        start_run(8'h99, 9'd5);
        wait_valid(ok);
        chk("busy_start_result", {ok, res_if.init, res_if.attr, res_if.timeout},
            {1'b1, 8'h20, 8'h60, 1'b1});
        @(negedge clk);
        chk("busy_start_single", {done, res_if.valid}, 2'b10);
        @(negedge clk);
        chk("busy_start_idle", 64'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
